// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard and stall controller for a classic 5-stage pipeline.
//            Detects load-use hazards, sequences branch flushes and freezes
//            the pipe while the data memory is busy. It also keeps a stalled-
//            cycle performance counter and a sticky memory-timeout flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FLUSH_CYCLES  1..7    flush cycles per taken branch
//   WAIT_MAX      1..255  memory-wait cycles before the timeout flag sets
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt        source operands of the ID instruction
//   ex_memread, ex_rt               load in EX and its destination register
//   ex_branch_taken                 branch resolved taken in EX
//   mem_req, mem_ready              MEM access pending / data memory done
//   pc_stall, ifid_stall, idex_stall   hold PC / IF-ID / ID-EX
//   ifid_flush, idex_flush             clear IF-ID / ID-EX
//   state        current FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)
//   stall_count  saturating count of cycles with pc_stall high
//   mem_timeout  sticky memory-timeout flag
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  localparam logic [7:0] c_WAIT_MAX   = 8'(WAIT_MAX);
  localparam logic [2:0] c_FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic       c_MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic [15:0] r_stall_count;
  logic        r_mem_timeout;
  logic        w_timeout_set;

  logic w_load_use;
  logic w_mem_stall;
  logic w_eval_run;
  logic w_pc_stall, w_ifid_stall, w_idex_stall, w_ifid_flush, w_idex_flush;

  // Register $0 is hard-wired to zero, so a load targeting it never hazards.
  assign w_load_use  = ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign w_mem_stall = mem_req && !mem_ready;

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_timeout_set   = 1'b0;
    w_eval_run      = 1'b0;
    w_pc_stall      = 1'b0;
    w_ifid_stall    = 1'b0;
    w_idex_stall    = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;

    case (r_state)
      ST_RUN: w_eval_run = 1'b1;

      ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          // Whole front end frozen; branch and load-use wait for memory.
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_stall = 1'b1;
          if (r_wait_cnt < c_WAIT_MAX) begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
          if (r_wait_cnt == c_WAIT_MAX) begin
            w_timeout_set = 1'b1;
          end
        end else begin
          // Memory finished: this same cycle behaves exactly like RUN.
          w_eval_run = 1'b1;
        end
      end

      ST_FLUSH: begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        if (w_mem_stall) begin
          // Flush sequence pauses while the memory is busy.
          w_pc_stall = 1'b1;
        end else if (r_flush_cnt == c_FLUSH_LAST) begin
          w_next_state    = ST_RUN;
          w_flush_cnt_nxt = 3'd0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 3'd1;
        end
      end

      default: begin
        // Unused encoding: outputs stay 0 and the FSM recovers to RUN.
        w_next_state    = ST_RUN;
        w_wait_cnt_nxt  = 8'd0;
        w_flush_cnt_nxt = 3'd0;
      end
    endcase

    if (w_eval_run) begin
      w_wait_cnt_nxt = 8'd0;
      w_next_state   = ST_RUN;
      if (w_mem_stall) begin
        w_pc_stall     = 1'b1;
        w_ifid_stall   = 1'b1;
        w_idex_stall   = 1'b1;
        w_next_state   = ST_MEM_WAIT;
        w_wait_cnt_nxt = 8'd1;
      end else if (ex_branch_taken) begin
        // The branch cycle itself is the first flush cycle.
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        if (c_MULTI_FLUSH) begin
          w_next_state    = ST_FLUSH;
          w_flush_cnt_nxt = 3'd1;
        end
      end else if (w_load_use) begin
        // Hold PC and IF-ID, insert one bubble into ID-EX.
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_flush_cnt   <= 3'd0;
      r_stall_count <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_pc_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Controls are forced low while reset is asserted, independent of inputs.
  assign pc_stall    = w_pc_stall   & ~reset;
  assign ifid_stall  = w_ifid_stall & ~reset;
  assign idex_stall  = w_idex_stall & ~reset;
  assign ifid_flush  = w_ifid_flush & ~reset;
  assign idex_flush  = w_idex_flush & ~reset;
  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire
